// File: rtl/cmp_share_ctrl.sv
// -----------------------------------------------------------------------------
// cmp_share_ctrl
//
// Shares one signed/unsigned less-than comparator between two requesters.
// Port 0 is the ALU (SLT/SLTU) and port 1 is the branch unit (BLT/BGE/BLTU/
// BGEU). A request is arbitrated in IDLE and its operands are latched. The
// compare runs for one cycle in EXEC. The 1-bit result, zero-extended to
// DATA_W, is then held in RESP until the owning requester accepts it.
//
// Configuration macro:
//   CMP_SHARE_FIXED_PRIO_EN  defined   : requester 1 always wins contention.
//                            undefined : round-robin; requester 0 wins the
//                                        first contention after reset.
//
// Ports:
//   clk_i                  clock; all state updates on the rising edge
//   rstn_i                 synchronous active-low reset
//   reqX_valid_i/ready_o   request handshake; ready is only ever high in IDLE
//   reqX_a_i, reqX_b_i     operands
//   reqX_op_i              00 LT, 01 LTU, 10 GE, 11 GEU
//   rspX_valid_o/ready_i   response handshake
//   rspX_r_o               bit 0 = compare outcome, upper bits zero
// -----------------------------------------------------------------------------
module cmp_share_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rstn_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic [1:0]        req0_op_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    input  logic [1:0]        req1_op_i,

    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_r_o,

    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_r_o
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        op_q;
    logic              gnt_id_q;
`ifndef CMP_SHARE_FIXED_PRIO_EN
    logic              last_grant_q;
`endif

    logic grant0;
    logic grant1;
    logic lt_u;
    logic lt_low;
    logic lt_s;
    logic lt;
    logic result;

    // Arbitration is only live in IDLE, so ready never rises elsewhere.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle) begin
`ifdef CMP_SHARE_FIXED_PRIO_EN
            grant1 = req1_valid_i;
            grant0 = req0_valid_i & ~req1_valid_i;
`else
            grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
            grant1 = req1_valid_i & ~grant0;
`endif
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    // Signed compare reuses the unsigned comparator on the magnitude bits;
    // differing sign bits decide the outcome on their own.
    always_comb begin
        lt_u   = a_q < b_q;
        lt_low = a_q[DATA_W-2:0] < b_q[DATA_W-2:0];
        case ({a_q[DATA_W-1], b_q[DATA_W-1]})
            2'b10:   lt_s = 1'b1;
            2'b01:   lt_s = 1'b0;
            default: lt_s = lt_low;
        endcase
        lt     = op_q[0] ? lt_u : lt_s;
        result = op_q[1] ? ~lt : lt;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            gnt_id_q     <= 1'b0;
`ifndef CMP_SHARE_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
            rsp0_valid_o <= 1'b0;
            rsp1_valid_o <= 1'b0;
            rsp0_r_o     <= '0;
            rsp1_r_o     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant0 || grant1) begin
                        a_q          <= grant1 ? req1_a_i  : req0_a_i;
                        b_q          <= grant1 ? req1_b_i  : req0_b_i;
                        op_q         <= grant1 ? req1_op_i : req0_op_i;
                        gnt_id_q     <= grant1;
`ifndef CMP_SHARE_FIXED_PRIO_EN
                        last_grant_q <= grant1;
`endif
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    if (gnt_id_q) begin
                        rsp1_r_o     <= {{(DATA_W-1){1'b0}}, result};
                        rsp1_valid_o <= 1'b1;
                    end else begin
                        rsp0_r_o     <= {{(DATA_W-1){1'b0}}, result};
                        rsp0_valid_o <= 1'b1;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    if (gnt_id_q ? rsp1_ready_i : rsp0_ready_i) begin
                        rsp0_valid_o <= 1'b0;
                        rsp1_valid_o <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmp_share_ctrl
//
// Self-checking bench for cmp_share_ctrl. The driver predicts the arbitration
// winner and the compare result, pushes them to a scoreboard queue, and a
// monitor pops and compares on every response handshake.
// -----------------------------------------------------------------------------
module tb_cmp_share_ctrl;

    localparam int unsigned DATA_W = 32;

    logic              clk_i;
    logic              rstn_i;
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [DATA_W-1:0] req0_a_i;
    logic [DATA_W-1:0] req0_b_i;
    logic [1:0]        req0_op_i;
    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [DATA_W-1:0] req1_a_i;
    logic [DATA_W-1:0] req1_b_i;
    logic [1:0]        req1_op_i;
    logic              rsp0_valid_o;
    logic              rsp0_ready_i;
    logic [DATA_W-1:0] rsp0_r_o;
    logic              rsp1_valid_o;
    logic              rsp1_ready_i;
    logic [DATA_W-1:0] rsp1_r_o;

    cmp_share_ctrl #(
        .DATA_W(DATA_W)
    ) u_dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req0_valid_i(req0_valid_i),
        .req0_ready_o(req0_ready_o),
        .req0_a_i    (req0_a_i),
        .req0_b_i    (req0_b_i),
        .req0_op_i   (req0_op_i),
        .req1_valid_i(req1_valid_i),
        .req1_ready_o(req1_ready_o),
        .req1_a_i    (req1_a_i),
        .req1_b_i    (req1_b_i),
        .req1_op_i   (req1_op_i),
        .rsp0_valid_o(rsp0_valid_o),
        .rsp0_ready_i(rsp0_ready_i),
        .rsp0_r_o    (rsp0_r_o),
        .rsp1_valid_o(rsp1_valid_o),
        .rsp1_ready_i(rsp1_ready_i),
        .rsp1_r_o    (rsp1_r_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] r;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    logic      m_last   = 1'b1;   // model of the round-robin pointer

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference compare written from the operation definitions directly.
    function automatic logic [DATA_W-1:0] model_cmp(input logic [1:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic lt;
        lt = op[0] ? (a < b) : ($signed(a) < $signed(b));
        return {{(DATA_W-1){1'b0}}, (op[1] ? ~lt : lt)};
    endfunction

    // Response monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk_i) begin
        sb_entry_t e;
        if (rsp0_valid_o && rsp0_ready_i) begin
            if (sb_q.size() == 0) begin
                check("rsp0_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("rsp0_id", 0, {{(DATA_W-1){1'b0}}, e.id});
                check("rsp0_r", rsp0_r_o, e.r);
            end
        end
        if (rsp1_valid_o && rsp1_ready_i) begin
            if (sb_q.size() == 0) begin
                check("rsp1_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("rsp1_id", 1, {{(DATA_W-1){1'b0}}, e.id});
                check("rsp1_r", rsp1_r_o, e.r);
            end
        end
    end

    // One full operation from IDLE back to IDLE. hold > 0 keeps rsp ready low
    // for that many response cycles with both request valids pending.
    task automatic do_op(input logic v0, input logic [1:0] op0,
                         input logic [DATA_W-1:0] a0, input logic [DATA_W-1:0] b0,
                         input logic v1, input logic [1:0] op1,
                         input logic [DATA_W-1:0] a1, input logic [DATA_W-1:0] b1,
                         input int hold, input string tag);
        logic              w;
        logic [DATA_W-1:0] exp_r;
        logic              done;
        sb_entry_t         e;
        if (v0 && v1) begin
`ifdef CMP_SHARE_FIXED_PRIO_EN
            w = 1'b1;
`else
            w = (m_last == 1'b1) ? 1'b0 : 1'b1;
`endif
        end else begin
            w = v1;
        end
        m_last = w;
        exp_r  = w ? model_cmp(op1, a1, b1) : model_cmp(op0, a0, b0);

        @(posedge clk_i); #1;
        req0_valid_i = v0; req0_op_i = op0; req0_a_i = a0; req0_b_i = b0;
        req1_valid_i = v1; req1_op_i = op1; req1_a_i = a1; req1_b_i = b1;
        rsp0_ready_i = (hold == 0);
        rsp1_ready_i = (hold == 0);
        @(negedge clk_i);
        check({tag, "_rdy0"}, {{(DATA_W-1){1'b0}}, req0_ready_o}, (w == 1'b0) ? 1 : 0);
        check({tag, "_rdy1"}, {{(DATA_W-1){1'b0}}, req1_ready_o}, (w == 1'b1) ? 1 : 0);
        e.id = w;
        e.r  = exp_r;
        sb_q.push_back(e);

        // EXEC cycle: scramble operands; they must not affect the result.
        @(posedge clk_i); #1;
        req0_valid_i = (hold > 0); req1_valid_i = (hold > 0);
        req0_a_i = $urandom; req0_b_i = $urandom;
        req1_a_i = $urandom; req1_b_i = $urandom;
        @(negedge clk_i);
        check({tag, "_exec_rsp"}, {{(DATA_W-2){1'b0}}, rsp1_valid_o, rsp0_valid_o}, 0);

        @(posedge clk_i); #1;
        @(negedge clk_i);
        check({tag, "_rsp_valid"}, {{(DATA_W-2){1'b0}}, rsp1_valid_o, rsp0_valid_o},
              w ? 2 : 1);
        for (int i = 0; i < hold; i++) begin
            if (i != 0) @(negedge clk_i);
            check({tag, "_hold_valid"}, {{(DATA_W-2){1'b0}}, rsp1_valid_o, rsp0_valid_o},
                  w ? 2 : 1);
            check({tag, "_hold_r"}, w ? rsp1_r_o : rsp0_r_o, exp_r);
            check({tag, "_hold_rdy"}, {{(DATA_W-2){1'b0}}, req1_ready_o, req0_ready_o}, 0);
        end
        if (hold > 0) begin
            @(posedge clk_i); #1;
            req0_valid_i = 1'b0; req1_valid_i = 1'b0;
            rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
        end

        done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            if (sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            check({tag, "_rsp_timeout"}, 0, 1);
            sb_q.delete();
        end
    endtask

    initial begin
        logic              rv0, rv1;
        logic [1:0]        rop0, rop1;
        logic [DATA_W-1:0] ra0, rb0, ra1, rb1;

        rstn_i = 1'b0;
        req0_valid_i = 1'b0; req0_a_i = '0; req0_b_i = '0; req0_op_i = '0;
        req1_valid_i = 1'b0; req1_a_i = '0; req1_b_i = '0; req1_op_i = '0;
        rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        @(negedge clk_i);
        check("reset_rsp_valid", {{(DATA_W-2){1'b0}}, rsp1_valid_o, rsp0_valid_o}, 0);
        check("reset_rsp0_r", rsp0_r_o, 0);
        check("reset_rsp1_r", rsp1_r_o, 0);
        check("reset_rdy", {{(DATA_W-2){1'b0}}, req1_ready_o, req0_ready_o}, 0);

        // Basic signed and unsigned compares on each port.
        do_op(1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 0, 2'b00, '0, '0, 0, "lt0");
        do_op(0, 2'b00, '0, '0, 1, 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 0, "ltu1");

        // Contention: round-robin 0,1,0,1 (fixed priority: 1,1,1,1).
        for (int i = 0; i < 4; i++) begin
            do_op(1, 2'b00, 32'h0000_0003, 32'h0000_0005,
                  1, 2'b10, 32'h0000_0003, 32'h0000_0005, 0, "contend");
        end

        // Equal operands, response stalled for 5 cycles.
        do_op(1, 2'b10, 32'h1234_5678, 32'h1234_5678, 0, 2'b00, '0, '0, 5, "ge_hold");

        // Sign boundary.
        do_op(0, 2'b00, '0, '0, 1, 2'b00, 32'h8000_0000, 32'h7FFF_FFFF, 0, "lt_bnd");
        do_op(0, 2'b00, '0, '0, 1, 2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 0, "ltu_bnd");
        do_op(1, 2'b11, 32'h0000_0000, 32'h0000_0000, 0, 2'b00, '0, '0, 0, "geu_eq");
        do_op(1, 2'b00, 32'h0000_0001, 32'hFFFF_FFFF, 0, 2'b00, '0, '0, 0, "lt_pos_neg");

        // Random mix of ports, ops and operands.
        for (int i = 0; i < 10; i++) begin
            rv0  = 1'($urandom_range(0, 1));
            rv1  = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
            rop0 = 2'($urandom_range(0, 3));
            rop1 = 2'($urandom_range(0, 3));
            ra0  = $urandom; rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
            ra1  = $urandom; rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
            do_op(rv0, rop0, ra0, rb0, rv1, rop1, ra1, rb1, 0, "rand");
        end

        // Reset during EXEC aborts the request without a response.
        @(posedge clk_i); #1;
        req0_valid_i = 1'b1; req0_op_i = 2'b00;
        req0_a_i = 32'hFFFF_FFFF; req0_b_i = 32'h0000_0001;
        @(negedge clk_i);
        check("abort_rdy0", {{(DATA_W-1){1'b0}}, req0_ready_o}, 1);
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        rstn_i = 1'b0;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("abort_rsp0_valid", {{(DATA_W-1){1'b0}}, rsp0_valid_o}, 0);
        check("abort_rsp0_r", rsp0_r_o, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("abort_no_rsp", {{(DATA_W-2){1'b0}}, rsp1_valid_o, rsp0_valid_o}, 0);
        end
        m_last = 1'b1;
        do_op(1, 2'b01, 32'h0000_0002, 32'h0000_0007,
              1, 2'b01, 32'h0000_0007, 32'h0000_0002, 0, "post_reset");

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
